// File: rtl/latency_dual_port_ram_if.sv
// rtl/latency_dual_port_ram_if.sv - request/response bundle for latency_dual_port_ram
//
// Groups both port request sets and their read data into one interface.
//   i_ena/i_enb     : port enable
//   i_wea/i_web     : 1 = write, 0 = read (when enabled)
//   i_addra/i_addrb : word address (AW bits)
//   i_dina/i_dinb   : write data
//   o_douta/o_doutb : registered read data
// Modports: master drives requests and observes read data; slave is the RAM.
interface latency_dual_port_ram_if #(
    parameter int DATA_WIDTH = 8,
    parameter int AW         = 4
) ();
    logic                  i_ena;
    logic                  i_wea;
    logic [AW-1:0]         i_addra;
    logic [DATA_WIDTH-1:0] i_dina;
    logic [DATA_WIDTH-1:0] o_douta;
    logic                  i_enb;
    logic                  i_web;
    logic [AW-1:0]         i_addrb;
    logic [DATA_WIDTH-1:0] i_dinb;
    logic [DATA_WIDTH-1:0] o_doutb;

    modport master (
        output i_ena, i_wea, i_addra, i_dina,
        output i_enb, i_web, i_addrb, i_dinb,
        input  o_douta, o_doutb
    );

    modport slave (
        input  i_ena, i_wea, i_addra, i_dina,
        input  i_enb, i_web, i_addrb, i_dinb,
        output o_douta, o_doutb
    );
endinterface

// File: rtl/latency_dual_port_ram.sv
// rtl/latency_dual_port_ram.sv - true dual-port RAM with per-port write/read latency
//
// Ports:
//   clk : single rising-edge clock for both ports
//   rst : synchronous active-high reset (clears outputs and in-flight requests,
//         memory contents are kept)
//   bus : latency_dual_port_ram_if slave modport carrying both ports
// A write sampled at edge k commits at edge k+W-1; a read sampled at edge k
// reads the array at k (read-first) and loads o_dout at edge k+R-1.
module latency_dual_port_ram #(
    parameter int WR_LATENCYA = 1,
    parameter int RD_LATENCYA = 1,
    parameter int WR_LATENCYB = 1,
    parameter int RD_LATENCYB = 1,
    parameter int DATA_WIDTH  = 8,
    parameter int MEM_DEPTH   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    latency_dual_port_ram_if.slave  bus
);
    localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [AW:0] DEPTH_W = (AW+1)'(MEM_DEPTH);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // Addresses beyond MEM_DEPTH exist only for non-power-of-2 depths.
    function automatic logic in_range(input logic [AW-1:0] addr);
        return ({1'b0, addr} < DEPTH_W);
    endfunction

    // Requests as sampled at the current edge.
    logic wa_req, ra_req, wb_req, rb_req;
    assign wa_req = bus.i_ena & bus.i_wea;
    assign ra_req = bus.i_ena & ~bus.i_wea;
    assign wb_req = bus.i_enb & bus.i_web;
    assign rb_req = bus.i_enb & ~bus.i_web;

    // Array words seen by reads sampled at this edge (before this edge's commits).
    logic [DATA_WIDTH-1:0] ra_word, rb_word;
    assign ra_word = (ra_req && in_range(bus.i_addra)) ? mem[bus.i_addra] : '0;
    assign rb_word = (rb_req && in_range(bus.i_addrb)) ? mem[bus.i_addrb] : '0;

    // Write requests committing at this edge.
    logic                  wa_v, wb_v;
    logic [AW-1:0]         wa_addr, wb_addr;
    logic [DATA_WIDTH-1:0] wa_data, wb_data;

    // Read results emerging at this edge.
    logic                  ra_v, rb_v;
    logic [DATA_WIDTH-1:0] ra_data, rb_data;

    generate
        if (WR_LATENCYA == 1) begin : g_wa_direct
            assign wa_v    = wa_req;
            assign wa_addr = bus.i_addra;
            assign wa_data = bus.i_dina;
        end else begin : g_wa_pipe
            localparam int N = WR_LATENCYA - 1;
            logic [N-1:0]          v;
            logic [AW-1:0]         a [N];
            logic [DATA_WIDTH-1:0] d [N];
            always_ff @(posedge clk) begin
                if (rst) begin
                    v <= '0;
                end else begin
                    v[0] <= wa_req;
                    for (int i = 1; i < N; i++) v[i] <= v[i-1];
                end
                a[0] <= bus.i_addra;
                d[0] <= bus.i_dina;
                for (int i = 1; i < N; i++) begin
                    a[i] <= a[i-1];
                    d[i] <= d[i-1];
                end
            end
            assign wa_v    = v[N-1];
            assign wa_addr = a[N-1];
            assign wa_data = d[N-1];
        end

        if (WR_LATENCYB == 1) begin : g_wb_direct
            assign wb_v    = wb_req;
            assign wb_addr = bus.i_addrb;
            assign wb_data = bus.i_dinb;
        end else begin : g_wb_pipe
            localparam int N = WR_LATENCYB - 1;
            logic [N-1:0]          v;
            logic [AW-1:0]         a [N];
            logic [DATA_WIDTH-1:0] d [N];
            always_ff @(posedge clk) begin
                if (rst) begin
                    v <= '0;
                end else begin
                    v[0] <= wb_req;
                    for (int i = 1; i < N; i++) v[i] <= v[i-1];
                end
                a[0] <= bus.i_addrb;
                d[0] <= bus.i_dinb;
                for (int i = 1; i < N; i++) begin
                    a[i] <= a[i-1];
                    d[i] <= d[i-1];
                end
            end
            assign wb_v    = v[N-1];
            assign wb_addr = a[N-1];
            assign wb_data = d[N-1];
        end

        if (RD_LATENCYA == 1) begin : g_ra_direct
            assign ra_v    = ra_req;
            assign ra_data = ra_word;
        end else begin : g_ra_pipe
            localparam int N = RD_LATENCYA - 1;
            logic [N-1:0]          v;
            logic [DATA_WIDTH-1:0] d [N];
            always_ff @(posedge clk) begin
                if (rst) begin
                    v <= '0;
                end else begin
                    v[0] <= ra_req;
                    for (int i = 1; i < N; i++) v[i] <= v[i-1];
                end
                d[0] <= ra_word;
                for (int i = 1; i < N; i++) d[i] <= d[i-1];
            end
            assign ra_v    = v[N-1];
            assign ra_data = d[N-1];
        end

        if (RD_LATENCYB == 1) begin : g_rb_direct
            assign rb_v    = rb_req;
            assign rb_data = rb_word;
        end else begin : g_rb_pipe
            localparam int N = RD_LATENCYB - 1;
            logic [N-1:0]          v;
            logic [DATA_WIDTH-1:0] d [N];
            always_ff @(posedge clk) begin
                if (rst) begin
                    v <= '0;
                end else begin
                    v[0] <= rb_req;
                    for (int i = 1; i < N; i++) v[i] <= v[i-1];
                end
                d[0] <= rb_word;
                for (int i = 1; i < N; i++) d[i] <= d[i-1];
            end
            assign rb_v    = v[N-1];
            assign rb_data = d[N-1];
        end
    endgenerate

    // Port B is written first so that port A's later assignment wins a
    // same-address collision. A reset edge blocks commits, including the
    // zero-latency path from the live inputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (wb_v && in_range(wb_addr)) mem[wb_addr] <= wb_data;
            if (wa_v && in_range(wa_addr)) mem[wa_addr] <= wa_data;
        end
    end

    // Outputs move only when a read result emerges; otherwise they hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.o_douta <= '0;
            bus.o_doutb <= '0;
        end else begin
            if (ra_v) bus.o_douta <= ra_data;
            if (rb_v) bus.o_doutb <= rb_data;
        end
    end
endmodule

// File: tb/tb_latency_dual_port_ram.sv
// tb/tb_latency_dual_port_ram.sv - self-checking bench for latency_dual_port_ram
module tb_latency_dual_port_ram;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    localparam int P_WRA = 3, P_RDA = 4, P_WRB = 2, P_RDB = 2, P_DEPTH = 12;

    latency_dual_port_ram_if #(.DATA_WIDTH(8), .AW(4)) bus_u ();
    latency_dual_port_ram_if #(.DATA_WIDTH(8), .AW(4)) bus_p ();
    latency_dual_port_ram_if #(.DATA_WIDTH(8), .AW(4)) bus_r ();

    latency_dual_port_ram #(.DATA_WIDTH(8), .MEM_DEPTH(16)) dut_u (
        .clk(clk), .rst(rst), .bus(bus_u));
    latency_dual_port_ram #(.WR_LATENCYA(P_WRA), .RD_LATENCYA(P_RDA),
        .WR_LATENCYB(P_WRB), .RD_LATENCYB(P_RDB),
        .DATA_WIDTH(8), .MEM_DEPTH(P_DEPTH)) dut_p (
        .clk(clk), .rst(rst), .bus(bus_p));
    latency_dual_port_ram #(.WR_LATENCYA(4), .RD_LATENCYB(4),
        .DATA_WIDTH(8), .MEM_DEPTH(16)) dut_r (
        .clk(clk), .rst(rst), .bus(bus_r));

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Directed vectors for the unit-latency instance: one row per edge.
    typedef struct {
        logic       ena, wea;
        logic [3:0] addra;
        logic [7:0] dina;
        logic       enb, web;
        logic [3:0] addrb;
        logic [7:0] dinb;
        logic [7:0] exp_a, exp_b;
    } vec_t;
    vec_t vecs[14];

    function automatic vec_t mk(input logic ena, input logic wea, input logic [3:0] addra,
                                input logic [7:0] dina, input logic enb, input logic web,
                                input logic [3:0] addrb, input logic [7:0] dinb,
                                input logic [7:0] exp_a, input logic [7:0] exp_b);
        vec_t v;
        v.ena = ena; v.wea = wea; v.addra = addra; v.dina = dina;
        v.enb = enb; v.web = web; v.addrb = addrb; v.dinb = dinb;
        v.exp_a = exp_a; v.exp_b = exp_b;
        return v;
    endfunction

    // Reference model for the latency instance: a word array plus queues of
    // scheduled commits and scheduled output updates, keyed by edge number.
    typedef struct { int t; logic [3:0] a; logic [7:0] d; } wr_t;
    typedef struct { int t; logic [7:0] d; } rd_t;
    wr_t wq_a[$], wq_b[$];
    rd_t rq_a[$], rq_b[$];
    logic [7:0] mm [P_DEPTH];
    logic [7:0] ea = 8'h00, eb = 8'h00;
    int now = 0;

    task automatic drive_p(input logic ena, input logic wea, input logic [3:0] addra,
                           input logic [7:0] dina, input logic enb, input logic web,
                           input logic [3:0] addrb, input logic [7:0] dinb);
        wr_t w;
        rd_t r;
        bus_p.i_ena = ena; bus_p.i_wea = wea; bus_p.i_addra = addra; bus_p.i_dina = dina;
        bus_p.i_enb = enb; bus_p.i_web = web; bus_p.i_addrb = addrb; bus_p.i_dinb = dinb;
        if (ena && !wea) begin
            r.t = now + P_RDA - 1;
            r.d = (int'(addra) < P_DEPTH) ? mm[addra] : 8'h00;
            rq_a.push_back(r);
        end
        if (enb && !web) begin
            r.t = now + P_RDB - 1;
            r.d = (int'(addrb) < P_DEPTH) ? mm[addrb] : 8'h00;
            rq_b.push_back(r);
        end
        if (ena && wea) begin
            w.t = now + P_WRA - 1; w.a = addra; w.d = dina;
            wq_a.push_back(w);
        end
        if (enb && web) begin
            w.t = now + P_WRB - 1; w.a = addrb; w.d = dinb;
            wq_b.push_back(w);
        end
        while (wq_b.size() > 0 && wq_b[0].t == now) begin
            w = wq_b.pop_front();
            if (int'(w.a) < P_DEPTH) mm[w.a] = w.d;
        end
        while (wq_a.size() > 0 && wq_a[0].t == now) begin
            w = wq_a.pop_front();
            if (int'(w.a) < P_DEPTH) mm[w.a] = w.d;
        end
        if (rq_a.size() > 0 && rq_a[0].t == now) begin
            r = rq_a.pop_front();
            ea = r.d;
        end
        if (rq_b.size() > 0 && rq_b[0].t == now) begin
            r = rq_b.pop_front();
            eb = r.d;
        end
        now++;
    endtask

    task automatic idle_ur();
        bus_u.i_ena = 0; bus_u.i_wea = 0; bus_u.i_addra = 0; bus_u.i_dina = 0;
        bus_u.i_enb = 0; bus_u.i_web = 0; bus_u.i_addrb = 0; bus_u.i_dinb = 0;
        bus_r.i_ena = 0; bus_r.i_wea = 0; bus_r.i_addra = 0; bus_r.i_dina = 0;
        bus_r.i_enb = 0; bus_r.i_web = 0; bus_r.i_addrb = 0; bus_r.i_dinb = 0;
    endtask

    task automatic idle_p_raw();
        bus_p.i_ena = 0; bus_p.i_wea = 0; bus_p.i_addra = 0; bus_p.i_dina = 0;
        bus_p.i_enb = 0; bus_p.i_web = 0; bus_p.i_addrb = 0; bus_p.i_dinb = 0;
    endtask

    initial begin
        vecs[0]  = mk(1, 1, 3, 8'hA5, 0, 0, 0, 8'h00, 8'h00, 8'h00);
        vecs[1]  = mk(1, 0, 3, 8'h00, 0, 0, 0, 8'h00, 8'hA5, 8'h00);
        vecs[2]  = mk(1, 1, 7, 8'h11, 1, 1, 7, 8'h22, 8'hA5, 8'h00);
        vecs[3]  = mk(1, 0, 7, 8'h00, 1, 0, 7, 8'h00, 8'h11, 8'h11);
        vecs[4]  = mk(1, 1, 2, 8'h55, 0, 0, 0, 8'h00, 8'h11, 8'h11);
        vecs[5]  = mk(1, 1, 2, 8'h66, 1, 0, 2, 8'h00, 8'h11, 8'h55);
        vecs[6]  = mk(0, 0, 0, 8'h00, 1, 0, 2, 8'h00, 8'h11, 8'h66);
        vecs[7]  = mk(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h11, 8'h66);
        vecs[8]  = mk(1, 0, 3, 8'h00, 1, 1, 3, 8'h99, 8'hA5, 8'h66);
        vecs[9]  = mk(0, 0, 0, 8'h00, 1, 0, 3, 8'h00, 8'hA5, 8'h99);
        vecs[10] = mk(1, 1, 4, 8'h44, 0, 0, 0, 8'h00, 8'hA5, 8'h99);
        vecs[11] = mk(1, 0, 4, 8'h00, 1, 0, 4, 8'h00, 8'h44, 8'h44);
        vecs[12] = mk(0, 1, 4, 8'hEE, 0, 1, 4, 8'hEE, 8'h44, 8'h44);
        vecs[13] = mk(1, 0, 4, 8'h00, 0, 0, 0, 8'h00, 8'h44, 8'h44);

        idle_ur();
        idle_p_raw();
        rst = 1'b1;
        tick();
        tick();
        check("rst_u_douta", bus_u.o_douta, 8'h00);
        check("rst_u_doutb", bus_u.o_doutb, 8'h00);
        check("rst_p_douta", bus_p.o_douta, 8'h00);
        check("rst_p_doutb", bus_p.o_doutb, 8'h00);
        check("rst_r_douta", bus_r.o_douta, 8'h00);
        check("rst_r_doutb", bus_r.o_doutb, 8'h00);
        rst = 1'b0;

        // Unit-latency vectors.
        for (int i = 0; i < 14; i++) begin
            bus_u.i_ena = vecs[i].ena; bus_u.i_wea = vecs[i].wea;
            bus_u.i_addra = vecs[i].addra; bus_u.i_dina = vecs[i].dina;
            bus_u.i_enb = vecs[i].enb; bus_u.i_web = vecs[i].web;
            bus_u.i_addrb = vecs[i].addrb; bus_u.i_dinb = vecs[i].dinb;
            tick();
            check($sformatf("vec%0d_douta", i), bus_u.o_douta, vecs[i].exp_a);
            check($sformatf("vec%0d_doutb", i), bus_u.o_doutb, vecs[i].exp_b);
        end
        idle_ur();

        // Randomized traffic on the latency instance: preload every word,
        // let the writes land, then mixed traffic including out-of-range.
        for (int c = 0; c < 420; c++) begin
            if (c < P_DEPTH)
                drive_p(1, 1, 4'(c), 8'($urandom), 0, 0, 4'h0, 8'h00);
            else if (c < P_DEPTH + 4 || c >= 410)
                drive_p(0, 0, 4'h0, 8'h00, 0, 0, 4'h0, 8'h00);
            else
                drive_p(($urandom_range(3, 0) != 0), 1'($urandom), 4'($urandom_range(15, 0)),
                        8'($urandom), ($urandom_range(3, 0) != 0), 1'($urandom),
                        4'($urandom_range(15, 0)), 8'($urandom));
            tick();
            check("rand_douta", bus_p.o_douta, ea);
            check("rand_doutb", bus_p.o_doutb, eb);
        end
        idle_p_raw();

        // Cross-port: A write latency 3, B read latency 2.
        bus_p.i_enb = 1; bus_p.i_web = 1; bus_p.i_addrb = 5; bus_p.i_dinb = 8'h01;
        tick();
        idle_p_raw();
        tick(); tick(); tick();
        bus_p.i_ena = 1; bus_p.i_wea = 1; bus_p.i_addra = 5; bus_p.i_dina = 8'h3C;
        tick();                                   // edge 0
        idle_p_raw();
        bus_p.i_enb = 1; bus_p.i_web = 0; bus_p.i_addrb = 5;
        tick();                                   // edge 1
        tick();                                   // edge 2
        check("xport_e1_old", bus_p.o_doutb, 8'h01);
        tick();                                   // edge 3
        check("xport_e2_old", bus_p.o_doutb, 8'h01);
        idle_p_raw();
        tick();                                   // edge 4
        check("xport_e3_new", bus_p.o_doutb, 8'h3C);
        tick();
        check("xport_hold", bus_p.o_doutb, 8'h3C);

        // Pipelined reads with read latency 4.
        for (int i = 0; i < 4; i++) begin
            bus_p.i_ena = 1; bus_p.i_wea = 1; bus_p.i_addra = 4'(i); bus_p.i_dina = 8'(i + 16);
            tick();
        end
        idle_p_raw();
        for (int i = 0; i < 4; i++) tick();
        for (int i = 0; i < 4; i++) begin
            bus_p.i_ena = 1; bus_p.i_wea = 0; bus_p.i_addra = 4'(i);
            tick();
        end
        check("pipe_e3", bus_p.o_douta, 8'h10);
        idle_p_raw();
        tick();
        check("pipe_e4", bus_p.o_douta, 8'h11);
        tick();
        check("pipe_e5", bus_p.o_douta, 8'h12);
        tick();
        check("pipe_e6", bus_p.o_douta, 8'h13);
        tick();
        check("pipe_hold1", bus_p.o_douta, 8'h13);
        tick();
        check("pipe_hold2", bus_p.o_douta, 8'h13);

        // Reset mid-operation: A write latency 4, B read latency 4.
        bus_r.i_enb = 1; bus_r.i_web = 1; bus_r.i_addrb = 0; bus_r.i_dinb = 8'h34;
        tick();
        bus_r.i_addrb = 1; bus_r.i_dinb = 8'h12;
        tick();
        bus_r.i_ena = 1; bus_r.i_wea = 0; bus_r.i_addra = 0;
        bus_r.i_enb = 1; bus_r.i_web = 0; bus_r.i_addrb = 1;
        tick();
        check("rstmid_pre_douta", bus_r.o_douta, 8'h34);
        idle_ur();
        tick(); tick(); tick();
        check("rstmid_pre_doutb", bus_r.o_doutb, 8'h12);
        bus_r.i_ena = 1; bus_r.i_wea = 1; bus_r.i_addra = 1; bus_r.i_dina = 8'h77;
        bus_r.i_enb = 1; bus_r.i_web = 0; bus_r.i_addrb = 0;
        tick();                                   // edge 0
        idle_ur();
        tick();                                   // edge 1
        rst = 1'b1;
        tick();                                   // edge 2
        check("rstmid_douta", bus_r.o_douta, 8'h00);
        check("rstmid_doutb", bus_r.o_doutb, 8'h00);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("rstmid_noread%0d", i), bus_r.o_doutb, 8'h00);
        end
        bus_r.i_ena = 1; bus_r.i_wea = 0; bus_r.i_addra = 1;
        bus_r.i_enb = 1; bus_r.i_web = 0; bus_r.i_addrb = 1;
        tick();
        check("rstmid_kept_a", bus_r.o_douta, 8'h12);
        idle_ur();
        tick(); tick(); tick();
        check("rstmid_kept_b", bus_r.o_doutb, 8'h12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/latency_dual_port_ram.md
# latency_dual_port_ram

True dual-port synchronous RAM with independently configurable write and read latency on each port (A and B). Both ports share one clock. Each port can read or write any location; requests enter a per-port latency pipeline before the memory array is updated or the read data reaches the output. The block serves as the latency-configurable memory model for the dual-port RAM verification environment.

## Interface

Parameters:
- WR_LATENCYA, default 1: port A write latency in cycles, legal range 1..16.
- RD_LATENCYA, default 1: port A read latency in cycles, legal range 1..16.
- WR_LATENCYB, default 1: port B write latency in cycles, legal range 1..16.
- RD_LATENCYB, default 1: port B read latency in cycles, legal range 1..16.
- DATA_WIDTH, default 8: word width in bits.
- MEM_DEPTH, default 16: number of words. AW = $clog2(MEM_DEPTH), minimum 1.

Ports. One clock; reset is synchronous and active-high.
- clk, input, 1: single clock for both ports, rising edge.
- rst, input, 1: synchronous, active-high reset.
- i_ena / i_enb, input, 1: port enable.
- i_wea / i_web, input, 1: 1 = write, 0 = read. Only meaningful when the port enable is 1.
- i_addra / i_addrb, input, AW: word address.
- i_dina / i_dinb, input, DATA_WIDTH: write data.
- o_douta / o_doutb, output, DATA_WIDTH: registered read data.

## Operation

- The request at a port is sampled on every rising clk edge.
  - en=1, we=1: write request.
  - en=1, we=0: read request.
  - en=0: idle. Idle inserts a bubble into the port's pipelines.
- **Write path (port X, latency W).**
  - addr and data pass through W-1 register stages.
  - The memory word is written at edge k+W-1, where k is the sampling edge.
  - W=1 means the array is written at the sampling edge itself.
- **Read path (port X, latency R).**
  - The array is read at sampling edge k. Read-first: the read returns contents before any write committing at that same edge.
  - The data passes through R-1 register stages.
  - o_doutX is loaded at edge k+R-1. R=1 gives a classic synchronous RAM.
- **o_dout hold rule.** o_doutX changes only when a read result emerges from the pipeline. It otherwise holds its last value, including during writes and idle cycles.
- **Ports are fully independent.** Simultaneous read/read, read/write and write/write on any addresses are allowed.
- **Write/write collision.** If both ports commit a write to the same address at the same edge, port A's data is stored and port B's is dropped.
- **Read/write same address, same edge.** The read returns the old data.
- **Out-of-range address** (addr ≥ MEM_DEPTH, possible when MEM_DEPTH is not a power of 2):
  - Writes are discarded.
  - Reads return 0.
- **Reset** (rst=1 at an edge):
  - o_douta and o_doutb are cleared to 0.
  - All in-flight write and read pipeline entries are invalidated. Pending writes never reach the array, and pending reads never update o_dout.
  - Memory contents are not cleared.
  - Requests sampled while rst=1 are ignored.

## Timing

- Write visibility, same port or other port: a read sampled at edge ≥ k+W returns the new data. A read sampled at edge k+W-1 or earlier returns the old data.
- Read data: o_doutX is valid after edge k+R-1 and is observable in the cycle following that edge.
- Back-to-back requests on every cycle are accepted; throughput is 1 request per port per cycle.
- Read results emerge in request order. There is no reordering across idle or write cycles.
- Reset values:
  - o_douta = 0 and o_doutb = 0 after the first reset edge.
  - Internal valid bits are all 0.
- After rst deasserts, the first request is sampled at the next edge.

## Test plan

- **Basic write/read, all latencies 1, port A.** Write 0xA5 to addr 3, then read addr 3 on the next cycle. Required: o_douta = 0xA5 after the read edge. o_doutb stays 0.
- **Cross-port with latency.** WR_LATENCYA=3, RD_LATENCYB=2. Write 0x3C to addr 5 at edge 0 via A. B reads addr 5 at edges 1, 2 and 3.
  - Reads at edges 1 and 2 return the old data.
  - The read at edge 3 returns 0x3C, on o_doutb after edge 4.
- **Pipelined reads.** RD_LATENCYA=4, array preloaded with addr i = i+0x10. Issue reads of addr 0,1,2,3 on consecutive edges 0..3.
  - o_douta = 0x10, 0x11, 0x12, 0x13 after edges 3, 4, 5, 6 respectively.
  - o_douta then holds 0x13 while idle.
- **Write collision.** Both ports write addr 7 at the same edge: A=0x11, B=0x22, equal write latencies. A subsequent read of addr 7 returns 0x11.
- **Read-during-write, same port pair.** Addr 2 holds 0x55. A writes 0x66 to addr 2 and B reads addr 2 at the same edge, all latencies 1.
  - o_doutb = 0x55.
  - The next B read returns 0x66.
- **Reset mid-operation.** WR_LATENCYA=4, RD_LATENCYB=4. Issue A write 0x77 to addr 1 and B read of addr 0, then assert rst for 1 cycle two edges later.
  - o_douta and o_doutb are 0 after the reset edge.
  - The pending read never appears.
  - A later read of addr 1 returns the pre-write contents, not 0x77.
